csr_mon_master: RTL and testbench

Initiator for the CSR monitor access port. It accepts single CSR read/write commands from the debug monitor command parser and halts the CPU. It then drives the `csr_*_mon` port of the CSR array and returns the pre-access CSR value on a valid/ready response channel. It sits between the monitor and the CSR array and is the only driver of the `csr_*_mon` signals.

---
 rtl/csr_mon_master.sv | 148 ++++++++++++++
 tb/tb_csr_mon_master.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mon_master.sv
// Initiator for the CSR monitor access port: halts the CPU, reads the CSR, optionally writes it, returns the old value.
// Define CSR_MON_RMW_EN to decode req_op into set-bits / clear-bits read-modify-write accesses.
module csr_mon_master #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_op,
    input  logic [11:0] req_adr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        cpu_run,
    output logic        cpu_stop_req,
    output logic        csr_radr_en_mon,
    output logic [11:0] csr_radr_mon,
    output logic [11:0] csr_wadr_mon,
    output logic        csr_we_mon,
    output logic [31:0] csr_wdata_mon,
    input  logic [31:0] csr_rdata_mon
);

    typedef enum logic [2:0] {IDLE, HALT, READ, WRITE, RESP} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 write_q;
    logic [11:0]          adr_q;
    logic [31:0]          wdata_q;
    logic [31:0]          wr_data;

`ifdef CSR_MON_RMW_EN
    logic [1:0] op_q;

    function automatic logic [31:0] write_value(input logic [31:0] old,
                                                input logic [31:0] mask,
                                                input logic [1:0]  op);
        case (op)
            2'b01:   write_value = old | mask;
            2'b10:   write_value = old & ~mask;
            default: write_value = mask;
        endcase
    endfunction

    assign wr_data = write_value(csr_rdata_mon, wdata_q, op_q);
`else
    logic [1:0] unused_op;
    assign unused_op = req_op;
    assign wr_data   = wdata_q;
`endif

    // Gated with rst so the port reads 0 while reset is held and 1 right after release.
    assign req_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            write_q         <= 1'b0;
            adr_q           <= '0;
            wdata_q         <= '0;
`ifdef CSR_MON_RMW_EN
            op_q            <= 2'b00;
`endif
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            cpu_stop_req    <= 1'b0;
            csr_radr_en_mon <= 1'b0;
            csr_radr_mon    <= '0;
            csr_wadr_mon    <= '0;
            csr_we_mon      <= 1'b0;
            csr_wdata_mon   <= '0;
        end else begin
            // Strobes are single-cycle; address and data are zero whenever their strobe is low.
            csr_radr_en_mon <= 1'b0;
            csr_radr_mon    <= '0;
            csr_we_mon      <= 1'b0;
            csr_wadr_mon    <= '0;
            csr_wdata_mon   <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q      <= req_write;
                        adr_q        <= req_adr;
                        wdata_q      <= req_wdata;
`ifdef CSR_MON_RMW_EN
                        op_q         <= req_op;
`endif
                        cnt          <= '0;
                        cpu_stop_req <= 1'b1;
                        state        <= HALT;
                    end
                end
                HALT: begin
                    if (!cpu_run) begin
                        csr_radr_en_mon <= 1'b1;
                        csr_radr_mon    <= adr_q;
                        state           <= READ;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                READ: begin
                    rsp_rdata <= csr_rdata_mon;
                    if (write_q) begin
                        csr_we_mon    <= 1'b1;
                        csr_wadr_mon  <= adr_q;
                        csr_wdata_mon <= wr_data;
                        state         <= WRITE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        rsp_err      <= 1'b0;
                        rsp_rdata    <= '0;
                        cpu_stop_req <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_mon_master.sv
// Scoreboard bench for csr_mon_master: a driver pushes expected strobes/responses, a monitor pops and compares.
module tb_csr_mon_master;
    localparam int TW    = 4;
    localparam int LIMIT = (1 << TW) - 1;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_op;
    logic [11:0] req_adr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cpu_run;
    logic        cpu_stop_req;
    logic        csr_radr_en_mon;
    logic [11:0] csr_radr_mon;
    logic [11:0] csr_wadr_mon;
    logic        csr_we_mon;
    logic [31:0] csr_wdata_mon;
    logic [31:0] csr_rdata_mon;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [11:0] adr;
        logic [31:0] data;
        int          cyc;
    } strb_t;

    rsp_t        rsp_q[$];
    strb_t       strb_q[$];
    logic [31:0] csr_arr [0:4095];
    logic [31:0] ref_csr [0:4095];
    logic [31:0] junk;
    int          cyc;
    int          n_tests;
    int          n_fail;
    bit          mon_en;
    int          hold_len;
    int          hold_id;
    logic [11:0] adr_tab [6] = '{12'h300, 12'h301, 12'h304, 12'h340, 12'h341, 12'h342};

    csr_mon_master #(.TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_op(req_op), .req_adr(req_adr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cpu_run(cpu_run), .cpu_stop_req(cpu_stop_req),
        .csr_radr_en_mon(csr_radr_en_mon), .csr_radr_mon(csr_radr_mon),
        .csr_wadr_mon(csr_wadr_mon), .csr_we_mon(csr_we_mon),
        .csr_wdata_mon(csr_wdata_mon), .csr_rdata_mon(csr_rdata_mon)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc  = 0;
        junk = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            junk = $urandom;
        end
    end

    // CSR array stand-in: combinational read, write on the strobe edge, read has priority.
    assign csr_rdata_mon = csr_radr_en_mon ? csr_arr[csr_radr_mon] : junk;

    initial begin
        for (int i = 0; i < 4096; i++) csr_arr[i] = 32'h0;
        csr_arr[12'h301] = 32'h4000_0100;
        csr_arr[12'h300] = 32'h0000_1800;
        forever begin
            @(posedge clk);
            if (csr_we_mon && !csr_radr_en_mon) csr_arr[csr_wadr_mon] <= csr_wdata_mon;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_write(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] op);
`ifdef CSR_MON_RMW_EN
        if (op == 2'b01) return old | wd;
        if (op == 2'b10) return old & ~wd;
        return wd;
`else
        if (op == 2'b11) return wd;
        return wd | (old & 32'h0);
`endif
    endfunction

    initial begin
        int left;
        int seen;
        left = 0;
        seen = 0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_id != seen) begin
                seen = hold_id;
                left = hold_len;
            end
            if (left > 0) begin
                rsp_ready = 1'b0;
                if (rsp_valid) left--;
            end else begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    initial begin
        rsp_t        r;
        strb_t       s;
        bit          pend;
        bit          ready_due;
        logic [31:0] prev_rdata;
        logic        prev_err;
        pend = 0;
        ready_due = 0;
        prev_rdata = 32'h0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                pend = 0;
                ready_due = 0;
            end else begin
                if (ready_due) check("req_ready_return", 32'(req_ready), 32'd1);
                ready_due = 0;
                check("strobe_exclusive", 32'(csr_radr_en_mon & csr_we_mon), 32'd0);
                check("radr_zero_idle", csr_radr_en_mon ? 32'd0 : 32'(csr_radr_mon), 32'd0);
                check("wadr_zero_idle", csr_we_mon ? 32'd0 : 32'(csr_wadr_mon), 32'd0);
                check("wdata_zero_idle", csr_we_mon ? 32'd0 : csr_wdata_mon, 32'd0);
                check("stop_vs_ready", 32'(cpu_stop_req), 32'(!req_ready));
                if (csr_radr_en_mon) begin
                    if (strb_q.size() == 0) check("read_unexpected", 32'd1, 32'd0);
                    else begin
                        s = strb_q.pop_front();
                        check("read_kind", 32'(s.wr), 32'd0);
                        check("read_adr", 32'(csr_radr_mon), 32'(s.adr));
                        check("read_cycle", 32'(cyc), 32'(s.cyc));
                    end
                end
                if (csr_we_mon) begin
                    if (strb_q.size() == 0) check("write_unexpected", 32'd1, 32'd0);
                    else begin
                        s = strb_q.pop_front();
                        check("write_kind", 32'(s.wr), 32'd1);
                        check("write_adr", 32'(csr_wadr_mon), 32'(s.adr));
                        check("write_data", csr_wdata_mon, s.data);
                        check("write_cycle", 32'(cyc), 32'(s.cyc));
                    end
                end
                if (rsp_valid) begin
                    check("ready_low_in_resp", 32'(req_ready), 32'd0);
                    if (pend) begin
                        check("rsp_rdata_stable", rsp_rdata, prev_rdata);
                        check("rsp_err_stable", 32'(rsp_err), 32'(prev_err));
                    end else if (rsp_q.size() == 0) begin
                        check("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_cycle", 32'(cyc), 32'(r.cyc));
                        check("rsp_rdata", rsp_rdata, r.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(r.err));
                    end
                    pend = !rsp_ready;
                    prev_rdata = rsp_rdata;
                    prev_err = rsp_err;
                    ready_due = rsp_ready;
                end else begin
                    if (pend) check("rsp_dropped", 32'd0, 32'd1);
                    pend = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (!(req_ready && !rsp_valid && rsp_q.size() == 0 && strb_q.size() == 0) && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic wr, input logic [1:0] op, input logic [11:0] adr,
                         input logic [31:0] wd, input int h);
        int          acc;
        int          w;
        logic [31:0] old;
        logic [31:0] nv;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = wr;
        req_op    = op;
        req_adr   = adr;
        req_wdata = wd;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        old = ref_csr[adr];
        if (h >= LIMIT) begin
            rsp_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: acc + LIMIT + 1});
        end else begin
            strb_q.push_back('{wr: 1'b0, adr: adr, data: 32'h0, cyc: acc + h + 2});
            if (wr) begin
                nv = model_write(old, wd, op);
                ref_csr[adr] = nv;
                strb_q.push_back('{wr: 1'b1, adr: adr, data: nv, cyc: acc + h + 3});
                rsp_q.push_back('{rdata: old, err: 1'b0, cyc: acc + h + 4});
            end else begin
                rsp_q.push_back('{rdata: old, err: 1'b0, cyc: acc + h + 3});
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_op    = 2'($urandom);
        req_adr   = 12'($urandom);
        req_wdata = $urandom;
        cpu_run   = (h > 0);
        if (h > 0) begin
            repeat (h) @(posedge clk);
            #1;
            cpu_run = 1'b0;
        end
    endtask

    task automatic check_outputs_zero();
        check("zero_req_ready", 32'(req_ready), 32'd0);
        check("zero_rsp_valid", 32'(rsp_valid), 32'd0);
        check("zero_rsp_rdata", rsp_rdata, 32'd0);
        check("zero_rsp_err", 32'(rsp_err), 32'd0);
        check("zero_cpu_stop_req", 32'(cpu_stop_req), 32'd0);
        check("zero_radr_en", 32'(csr_radr_en_mon), 32'd0);
        check("zero_radr", 32'(csr_radr_mon), 32'd0);
        check("zero_wadr", 32'(csr_wadr_mon), 32'd0);
        check("zero_we", 32'(csr_we_mon), 32'd0);
        check("zero_wdata", csr_wdata_mon, 32'd0);
    endtask

    task automatic reset_during(input bit at_write);
        wait_idle();
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_op    = 2'b00;
        req_adr   = 12'h340;
        req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cpu_run   = !at_write;
        if (at_write) repeat (2) @(posedge clk);
        @(negedge clk);
        if (at_write) check("we_before_rst", 32'(csr_we_mon), 32'd1);
        else check("stop_before_rst", 32'(cpu_stop_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_outputs_zero();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_run = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 32'd1);
        mon_en = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        mon_en = 1'b0;
        hold_len = 0;
        hold_id = 0;
        rst = 1'b0;
        cpu_run = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_op = 2'b00;
        req_adr = 12'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 4096; i++) ref_csr[i] = 32'h0;
        ref_csr[12'h301] = 32'h4000_0100;
        ref_csr[12'h300] = 32'h0000_1800;

        #1 rst = 1'b1;
        #2;
        check_outputs_zero();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);
        mon_en = 1'b1;

        issue(1'b0, 2'b00, 12'h301, 32'h0, 0);
        issue(1'b1, 2'b00, 12'h340, 32'hDEAD_BEEF, 0);
        issue(1'b0, 2'b00, 12'h340, 32'h0, 0);

        issue(1'b1, 2'b00, 12'h304, 32'h0000_0008, 0);
        issue(1'b1, 2'b01, 12'h304, 32'h0000_0880, 0);
        issue(1'b1, 2'b10, 12'h304, 32'h0000_0008, 0);
        issue(1'b0, 2'b00, 12'h304, 32'h0, 0);

        issue(1'b0, 2'b00, 12'h300, 32'h0, LIMIT + 5);
        issue(1'b1, 2'b00, 12'h341, 32'h0000_1234, LIMIT);
        issue(1'b1, 2'b00, 12'h341, 32'h5555_AAAA, LIMIT - 1);
        issue(1'b0, 2'b00, 12'h341, 32'h0, 0);

        wait_idle();
        hold_len = 10;
        hold_id++;
        issue(1'b0, 2'b00, 12'h340, 32'h0, 5);

        reset_during(1'b0);
        reset_during(1'b1);
        issue(1'b0, 2'b00, 12'h340, 32'h0, 0);

        for (int i = 0; i < 80; i++) begin
            int          sel;
            int          h;
            logic [11:0] a;
            a = adr_tab[$urandom_range(0, 5)];
            sel = $urandom_range(0, 9);
            if (sel < 6) h = $urandom_range(0, 3);
            else if (sel < 8) h = $urandom_range(4, LIMIT - 1);
            else h = $urandom_range(LIMIT, LIMIT + 4);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, h);
        end

        wait_idle();
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("strobe_queue_drained", 32'(strb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
